alu_exec_unit: RTL

Parametrised, handshaked execute unit that supersedes the combinational ALU-op decoder plus ALU pair. It decodes opcode/funct3/funct7, computes the result and presents it through a registered valid/ready output. The base RV32I ops complete in one cycle. Optional RV32M multiply/divide runs iteratively over XLEN cycles. It sits between the decode stage and writeback in the RISC-V core.

---
 rtl/alu_exec_unit.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_exec_unit                                                   |
// | Purpose  : Handshaked RISC-V execute unit. It decodes opcode/funct3/funct7,|
// |            computes the RV32I ALU result in one cycle and presents it      |
// |            through a registered valid/ready result stage.                  |
// |            With MULDIV_EN it also runs RV32M mul/div on an iterative       |
// |            shift-add / restoring engine that takes XLEN+1 cycles.          |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            in_valid/in_ready   : request handshake                         |
// |            opcode/funct3/funct7: instruction fields                        |
// |            op_a/op_b           : operands (rs1/PC, rs2/imm)                |
// |            out_valid/out_ready : result handshake                          |
// |            result/illegal      : result and unsupported-encoding flag      |
// |            busy                : iterative engine active                   |
// | Options  : MULDIV_EN - compiles in the M extension and the CALC state      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_f7_base    = 7'b0000000;
  localparam logic [6:0] c_f7_alt     = 7'b0100000;
  localparam logic [6:0] c_f7_muldiv  = 7'b0000001;

  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic            w_alt_sel;
  logic [XLEN-1:0] w_base_res;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_ill;
  logic            w_md_start;   // accepted request needs the iterative engine

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = op_b[SHW-1:0];

  // OP uses funct7 as a whole; OP-IMM only looks at funct7[5] for the shift-right pair.
  assign w_alt_sel = (opcode == c_opc_op) ? (funct7 == c_f7_alt)
                                          : (funct7[5] && (funct3 == 3'b101));

  always_comb begin
    w_base_res = '0;
    case (funct3)
      3'b000:  w_base_res = w_alt_sel ? (op_a - op_b) : (op_a + op_b);
      3'b001:  w_base_res = op_a << w_shamt;
      3'b010:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  w_base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100:  w_base_res = op_a ^ op_b;
      3'b101:  w_base_res = w_alt_sel ? XLEN'($signed(op_a) >>> w_shamt) : (op_a >> w_shamt);
      3'b110:  w_base_res = op_a | op_b;
      default: w_base_res = op_a & op_b;
    endcase
  end

`ifdef MULDIV_EN
  localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};
`endif

  // Decode: single-cycle result, illegal flag, and whether the engine is needed.
  always_comb begin
    w_alu_res  = op_b;
    w_alu_ill  = 1'b0;
    w_md_start = 1'b0;
    case (opcode)
      c_opc_op_imm: w_alu_res = w_base_res;
      c_opc_op: begin
        if (funct7 == c_f7_base) begin
          w_alu_res = w_base_res;
        end else if (funct7 == c_f7_alt) begin
          if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
            w_alu_res = w_base_res;
          end else begin
            w_alu_res = '0;
            w_alu_ill = 1'b1;
          end
        end else if (funct7 == c_f7_muldiv) begin
`ifdef MULDIV_EN
          w_alu_res = '0;
          // Divide-by-zero and signed overflow resolve immediately.
          if (funct3[2] && (op_b == '0)) begin
            w_alu_res = funct3[1] ? op_a : '1;
          end else if (funct3[2] && !funct3[0] && (op_a == c_most_neg) && (op_b == '1)) begin
            w_alu_res = funct3[1] ? '0 : op_a;
          end else begin
            w_md_start = 1'b1;
          end
`else
          w_alu_res = '0;
          w_alu_ill = 1'b1;
`endif
        end else begin
          w_alu_res = '0;
          w_alu_ill = 1'b1;
        end
      end
      c_opc_branch: w_alu_res = op_a - op_b;
      c_opc_jalr:   w_alu_res = op_a + op_b;
      default:      w_alu_res = op_b;
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [SHW:0] c_last_cnt = (SHW+1)'(XLEN);

  state_t          state_q, state_d;
  logic [SHW:0]    cnt_q, cnt_d;
  // Shared engine registers: multiply keeps {hi,lo} = partial product / multiplier,
  // divide keeps hi = partial remainder, lo = dividend shifting into quotient.
  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            md_div_q, md_div_d;
  logic            hi_sel_q, hi_sel_d;
  logic            neg_q, neg_d;

  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_trial;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_md_res;
  logic            w_calc_done;

  // Engine works on magnitudes; signs are reapplied in the fixup cycle.
  assign w_a_neg = op_a[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                                    (funct3 == 3'b100) || (funct3 == 3'b110));
  assign w_b_neg = op_b[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                                    (funct3 == 3'b110));
  assign w_a_mag = w_a_neg ? -op_a : op_a;
  assign w_b_mag = w_b_neg ? -op_b : op_b;

  assign w_mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign w_div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, opnd_q};
  assign w_calc_done = (state_q == CALC) && (cnt_q == c_last_cnt);

  always_comb begin
    w_prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    w_quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    w_rem_fix  = neg_q ? -acc_hi_q : acc_hi_q;
    if (md_div_q) begin
      w_md_res = hi_sel_q ? w_rem_fix : w_quo_fix;
    end else begin
      w_md_res = hi_sel_q ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    md_div_d = md_div_q;
    hi_sel_d = hi_sel_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (w_accept && w_md_start) begin
          state_d  = CALC;
          cnt_d    = '0;
          acc_hi_d = '0;
          md_div_d = funct3[2];
          hi_sel_d = funct3[2] ? funct3[1] : (funct3 != 3'b000);
          if (funct3[2]) begin
            acc_lo_d = w_a_mag;
            opnd_d   = w_b_mag;
            neg_d    = funct3[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
          end else begin
            acc_lo_d = w_b_mag;
            opnd_d   = w_a_mag;
            neg_d    = w_a_neg ^ w_b_neg;
          end
        end
      end
      CALC: begin
        if (w_calc_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (md_div_q) begin
            if (!w_div_trial[XLEN]) begin
              acc_hi_d = w_div_trial[XLEN-1:0];
              acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
              acc_hi_d = w_div_shift[XLEN-1:0];
              acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = w_mul_sum[XLEN:1];
            acc_lo_d = {w_mul_sum[0], acc_lo_q[XLEN-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      md_div_q <= 1'b0;
      hi_sel_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      md_div_q <= md_div_d;
      hi_sel_q <= hi_sel_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q == CALC);
`else
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
`endif

  // Result register: holds until taken; a new load on the draining edge wins.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    illegal_d   = illegal_q;
    if (w_accept && !w_md_start) begin
      out_valid_d = 1'b1;
      result_d    = w_alu_res;
      illegal_d   = w_alu_ill;
    end
`ifdef MULDIV_EN
    if (w_calc_done) begin
      out_valid_d = 1'b1;
      result_d    = w_md_res;
      illegal_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire
